// File: rtl/enemy_bullet_if.sv
// Shooter/player geometry in, bullet rectangle and event pulses out.
// master drives the game-side inputs; slave is the enemy_bullet block.
interface enemy_bullet_if;
    logic       shooter_valid_i;
    logic [9:0] shooter_left_i;
    logic [9:0] shooter_right_i;
    logic [9:0] shooter_bot_i;
    logic [9:0] player_left_i;
    logic [9:0] player_right_i;
    logic [9:0] player_top_i;
    logic       shield_hit_i;
    logic       bullet_active_o;
    logic [9:0] bullet_left_o;
    logic [9:0] bullet_top_o;
    logic [9:0] bullet_bot_o;
    logic       fire_o;
    logic       player_hit_o;

    modport master (
        output shooter_valid_i, shooter_left_i, shooter_right_i, shooter_bot_i,
        output player_left_i, player_right_i, player_top_i, shield_hit_i,
        input  bullet_active_o, bullet_left_o, bullet_top_o, bullet_bot_o,
        input  fire_o, player_hit_o
    );

    modport slave (
        input  shooter_valid_i, shooter_left_i, shooter_right_i, shooter_bot_i,
        input  player_left_i, player_right_i, player_top_i, shield_hit_i,
        output bullet_active_o, bullet_left_o, bullet_top_o, bullet_bot_o,
        output fire_o, player_hit_o
    );
endinterface

// File: rtl/enemy_bullet.sv
// Single enemy bullet: cooldown, launch from shooter, per-frame fall, player/shield collision.
// Optional ENEMY_BULLET_RANDOM_EN adds an LFSR-jittered cooldown; all outputs registered.
module enemy_bullet #(
    parameter int         delay_frames_p = 120,
    parameter int         speed_p        = 4,
    parameter int         bullet_w_p     = 2,
    parameter int         bullet_h_p     = 8,
    parameter logic [9:0] screen_bot_p   = 10'd479
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          frame_i,
    input  logic          enable_i,
    enemy_bullet_if.slave bus
);

    localparam int CW = $clog2(delay_frames_p + 32) + 1;

    typedef enum logic [1:0] {IDLE, COOLDOWN, FLYING} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          active_q;
    logic          fire_q;
    logic          hit_q;
    logic [9:0]    left_q;
    logic [9:0]    top_q;
    logic [9:0]    bot_q;

    logic [CW-1:0] term_w;
    logic [10:0]   sum_w;
    logic [9:0]    launch_left_d;
    logic [9:0]    launch_top_d;
    logic [9:0]    launch_bot_d;
    logic          overlap_w;
    logic          off_screen_w;
    logic          cooldown_entry_w;

    assign sum_w         = {1'b0, bus.shooter_left_i} + {1'b0, bus.shooter_right_i};
    assign launch_left_d = sum_w[10:1] - 10'(bullet_w_p / 2);
    assign launch_top_d  = bus.shooter_bot_i + 10'd1;
    assign launch_bot_d  = bus.shooter_bot_i + 10'(bullet_h_p);

    assign overlap_w = (left_q <= bus.player_right_i)
                    && (({1'b0, left_q} + 11'(bullet_w_p - 1)) >= {1'b0, bus.player_left_i})
                    && (bot_q >= bus.player_top_i);

    assign off_screen_w = ({1'b0, top_q} + 11'(speed_p + bullet_h_p - 1)) > {1'b0, screen_bot_p};

    assign cooldown_entry_w = enable_i
        && ((state_q == IDLE)
         || ((state_q == FLYING) && (bus.shield_hit_i || (frame_i && (overlap_w || off_screen_w)))));

`ifdef ENEMY_BULLET_RANDOM_EN
    logic [7:0]    lfsr_q;
    logic [CW-1:0] term_q;

    // Terminal count is frozen at cooldown entry so the LFSR can keep running meanwhile.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lfsr_q <= 8'hA5;
            term_q <= CW'(delay_frames_p - 1);
        end else begin
            if (frame_i)
                lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            if (cooldown_entry_w)
                term_q <= CW'(delay_frames_p - 1) + CW'(lfsr_q[4:0]);
        end
    end

    assign term_w = term_q;
`else
    assign term_w = CW'(delay_frames_p - 1);
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            active_q <= 1'b0;
            fire_q   <= 1'b0;
            hit_q    <= 1'b0;
            left_q   <= '0;
            top_q    <= '0;
            bot_q    <= 10'(bullet_h_p - 1);
        end else begin
            fire_q <= 1'b0;
            hit_q  <= 1'b0;
            if (!enable_i) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                active_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= COOLDOWN;
                        cnt_q   <= '0;
                    end
                    COOLDOWN: begin
                        if (frame_i) begin
                            if (cnt_q >= term_w) begin
                                // Saturated: wait here for a live shooter.
                                if (bus.shooter_valid_i) begin
                                    state_q  <= FLYING;
                                    fire_q   <= 1'b1;
                                    active_q <= 1'b1;
                                    left_q   <= launch_left_d;
                                    top_q    <= launch_top_d;
                                    bot_q    <= launch_bot_d;
                                end
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                    end
                    FLYING: begin
                        if (bus.shield_hit_i) begin
                            state_q  <= COOLDOWN;
                            cnt_q    <= '0;
                            active_q <= 1'b0;
                        end else if (frame_i) begin
                            if (overlap_w) begin
                                state_q  <= COOLDOWN;
                                cnt_q    <= '0;
                                active_q <= 1'b0;
                                hit_q    <= 1'b1;
                            end else if (off_screen_w) begin
                                state_q  <= COOLDOWN;
                                cnt_q    <= '0;
                                active_q <= 1'b0;
                            end else begin
                                top_q <= top_q + 10'(speed_p);
                                bot_q <= bot_q + 10'(speed_p);
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.bullet_active_o = active_q;
    assign bus.bullet_left_o   = left_q;
    assign bus.bullet_top_o    = top_q;
    assign bus.bullet_bot_o    = bot_q;
    assign bus.fire_o          = fire_q;
    assign bus.player_hit_o    = hit_q;

endmodule
